mips_irq_controller: RTL and testbench
======================================

Name: mips_irq_controller

Overview:
- Interrupt sequencer for the single-cycle MIPS DataPath.
- Synchronises the external INT, INTD and NMI lines and accepts a request only at an instruction boundary.
- On acceptance it saves the return PC, redirects the datapath PC to a handler vector and tracks handler nesting until ERET.
- Sits beside the PC register and drives its redirect mux.

Parameters:
- WIDTH, 32, PC/EPC width.
- INT_VECTOR, 32'h0000_0080, handler address for maskable INT.
- NMI_VECTOR, 32'h0000_0100, handler address for NMI.
- SYNC_STAGES, 2, synchroniser depth on INT, INTD and NMI (minimum 2).

Ports:
- clk  in  1  system clock; rising edge.
- initiate  in  1  asynchronous, active-low reset.
- INT  in  1  maskable interrupt, level-sensitive, asynchronous.
- INTD  in  1  interrupt disable; 1 masks INT. Asynchronous.
- NMI  in  1  non-maskable interrupt, rising-edge-sensitive, asynchronous.
- instr_done  in  1  datapath retires an instruction this cycle (safe boundary).
- pc_next  in  WIDTH  address of the next sequential instruction; valid with instr_done.
- eret  in  1  retiring instruction is ERET; qualified by instr_done.
- redirect  out  1  one-cycle pulse: PC <= pc_target; flush fetch.
- pc_target  out  WIDTH  redirect address; valid only while redirect=1, else 0.
- epc  out  WIDTH  saved return PC of the INT level.
- nmi_epc  out  WIDTH  saved return PC of the NMI level.
- cause  out  2  00 none, 01 INT, 10 NMI.
- in_handler  out  1  1 while any handler is active.
- int_ack  out  1  one-cycle pulse when INT is accepted.
- nmi_ack  out  1  one-cycle pulse when NMI is accepted.

Behaviour:
- Reset (initiate=0, asynchronous):
  - State is IDLE.
  - All outputs are 0: epc, nmi_epc, cause, redirect, acks.
  - Synchronisers and nmi_pending are cleared.
  - Applies mid-handler: a pending NMI and both saved PCs are lost.
- Input path:
  - INT, INTD and NMI each pass through SYNC_STAGES flops.
  - NMI: a rising edge on the synchronised value sets nmi_pending. nmi_pending clears only on NMI acceptance. Further edges while pending merge into the one pending request.
  - int_req = int_sync & ~intd_sync, evaluated only at a boundary.
- FSM states: IDLE, ENTER, IN_INT, IN_NMI, EXIT. State register nested=1 means the NMI preempted an INT handler.
- IDLE:
  - On instr_done with nmi_pending: nmi_epc <= pc_next, target=NMI, nmi_ack=1, go to ENTER.
  - Else on instr_done with int_req: epc <= pc_next, target=INT, int_ack=1, go to ENTER.
  - NMI beats INT when both are present.
- ENTER (exactly 1 cycle):
  - redirect=1; pc_target = vector of the accepted source; cause = that source.
  - Next state is IN_NMI or IN_INT.
- IN_INT:
  - On instr_done & eret: go to EXIT with target epc. ERET beats a simultaneous pending NMI; the NMI stays pending and is taken from IDLE.
  - Else on instr_done & nmi_pending: nmi_epc <= pc_next, nested=1, nmi_ack=1, go to ENTER.
  - INT is ignored while in the handler.
- IN_NMI:
  - On instr_done & eret: go to EXIT with target nmi_epc.
  - A new NMI edge stays pending (no nesting of NMI within NMI).
- EXIT (exactly 1 cycle):
  - redirect=1; pc_target = saved PC; cause = the source being left.
  - Next state is IN_INT with nested<=0 if nested=1, otherwise IDLE.
- in_handler = (state != IDLE).
- cause = 00 in IDLE; otherwise the current or transitioning source.
- Latency:
  - Asynchronous INT assertion to first possible acceptance is SYNC_STAGES cycles plus wait for instr_done.
  - Acceptance to redirect is 1 cycle. ENTER occupies the acceptance cycle + 1.
- Boundary rules:
  - instr_done in ENTER or EXIT is ignored. The datapath does not retire during a redirect cycle.
  - eret while in IDLE is ignored (no redirect).
  - A change of INTD matters only at an IDLE boundary.
  - epc and nmi_epc hold their values until overwritten.

Decomposition:
- Package mips_irq_pkg holds:
  - the FSM state encoding;
  - the CAUSE_NONE/INT/NMI codes;
  - the default INT_VECTOR/NMI_VECTOR constants.
- Sub-module irq_sync_edge: SYNC_STAGES-flop synchroniser with rising-edge output.
  - Used once for NMI (edge output).
  - Used for INT and INTD with the level output only.

Test Plan:
- INT=1, INTD=0; instr_done with pc_next=0x40 after sync:
  - int_ack pulse.
  - Next cycle: redirect=1, pc_target=0x80.
  - epc=0x40, cause=01, in_handler=1.
- INT=1, INTD=1 for 20 boundaries -> no ack, no redirect. Then INTD=0 -> accepted at the first boundary after sync.
- In IN_INT, NMI edge; instr_done with pc_next=0x88:
  - nmi_epc=0x88, redirect to 0x100, nested.
  - ERET -> redirect to 0x88, state IN_INT, cause=01.
  - ERET -> redirect to 0x40, IDLE.
- INT and NMI edge present at the same boundary (pc_next=0x20) -> nmi_ack only, target 0x100. After ERET, INT is taken at the next boundary.
- ERET and pending NMI at the same IN_INT boundary:
  - First redirect to epc, then IDLE.
  - NMI accepted at the next instr_done.
- initiate=0 during IN_NMI:
  - Immediately all outputs are 0, state IDLE.
  - After release, no redirect without new stimulus.

Source files
------------

// File: rtl/mips_irq_pkg.sv
// Shared types and constants for the MIPS interrupt sequencer.
package mips_irq_pkg;

  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    IN_INT,
    IN_NMI,
    EXIT
  } irq_state_e;

  typedef logic [CAUSE_W-1:0] cause_t;

  localparam cause_t CAUSE_NONE = 2'b00;
  localparam cause_t CAUSE_INT  = 2'b01;
  localparam cause_t CAUSE_NMI  = 2'b10;

  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0080;
  localparam logic [31:0] DEF_NMI_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with level and rising-edge outputs.
module irq_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/mips_irq_controller.sv
// Interrupt sequencer: takes INT/NMI at instruction boundaries, redirects the PC
// to the handler vector, and unwinds (possibly nested) handlers on ERET.
module mips_irq_controller
  import mips_irq_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] INT_VECTOR = WIDTH'(DEF_INT_VECTOR),
  parameter logic [WIDTH-1:0] NMI_VECTOR = WIDTH'(DEF_NMI_VECTOR),
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             initiate,
  input  logic             INT,
  input  logic             INTD,
  input  logic             NMI,
  input  logic             instr_done,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             eret,
  output logic             redirect,
  output logic [WIDTH-1:0] pc_target,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] nmi_epc,
  output cause_t           cause,
  output logic             in_handler,
  output logic             int_ack,
  output logic             nmi_ack
);

  logic int_lvl, intd_lvl, nmi_rise;
  logic int_rise, intd_rise, nmi_lvl;
  logic unused_sync;

  irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_int (
    .clk(clk), .rst_n(initiate), .async_in(INT), .level(int_lvl), .rise(int_rise)
  );
  irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_intd (
    .clk(clk), .rst_n(initiate), .async_in(INTD), .level(intd_lvl), .rise(intd_rise)
  );
  irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_nmi (
    .clk(clk), .rst_n(initiate), .async_in(NMI), .level(nmi_lvl), .rise(nmi_rise)
  );

  assign unused_sync = int_rise ^ intd_rise ^ nmi_lvl;

  irq_state_e       state_q, state_d;
  logic             nested_q, nested_d;
  logic             src_nmi_q, src_nmi_d;  // source of the current ENTER/EXIT redirect
  logic             nmi_pending_q, nmi_pending_d;
  logic [WIDTH-1:0] epc_d, nmi_epc_d, target_d;
  cause_t           cause_d;
  logic             int_req;

  assign int_req = int_lvl & ~intd_lvl;

  always_ff @(posedge clk or negedge initiate) begin
    if (!initiate) begin
      state_q       <= IDLE;
      nested_q      <= 1'b0;
      src_nmi_q     <= 1'b0;
      nmi_pending_q <= 1'b0;
      epc           <= '0;
      nmi_epc       <= '0;
      redirect      <= 1'b0;
      pc_target     <= '0;
      cause         <= CAUSE_NONE;
      in_handler    <= 1'b0;
    end else begin
      state_q       <= state_d;
      nested_q      <= nested_d;
      src_nmi_q     <= src_nmi_d;
      nmi_pending_q <= nmi_pending_d;
      epc           <= epc_d;
      nmi_epc       <= nmi_epc_d;
      redirect      <= (state_d == ENTER) || (state_d == EXIT);
      pc_target     <= target_d;
      cause         <= cause_d;
      in_handler    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    nested_d  = nested_q;
    src_nmi_d = src_nmi_q;
    epc_d     = epc;
    nmi_epc_d = nmi_epc;
    int_ack   = 1'b0;
    nmi_ack   = 1'b0;
    target_d  = '0;
    cause_d   = CAUSE_NONE;

    unique case (state_q)
      IDLE: begin
        if (instr_done && nmi_pending_q) begin
          nmi_epc_d = pc_next;
          src_nmi_d = 1'b1;
          nmi_ack   = 1'b1;
          state_d   = ENTER;
        end else if (instr_done && int_req) begin
          epc_d     = pc_next;
          src_nmi_d = 1'b0;
          int_ack   = 1'b1;
          state_d   = ENTER;
        end
      end
      ENTER: state_d = src_nmi_q ? IN_NMI : IN_INT;
      IN_INT: begin
        // ERET wins over a simultaneous NMI; the NMI is then taken from IDLE
        if (instr_done && eret) begin
          src_nmi_d = 1'b0;
          state_d   = EXIT;
        end else if (instr_done && nmi_pending_q) begin
          nmi_epc_d = pc_next;
          nested_d  = 1'b1;
          src_nmi_d = 1'b1;
          nmi_ack   = 1'b1;
          state_d   = ENTER;
        end
      end
      IN_NMI: begin
        if (instr_done && eret) begin
          src_nmi_d = 1'b1;
          state_d   = EXIT;
        end
      end
      EXIT: begin
        if (nested_q) begin
          nested_d = 1'b0;
          state_d  = IN_INT;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    nmi_pending_d = (nmi_pending_q & ~nmi_ack) | nmi_rise;

    // Output values for the state being entered, registered alongside it
    case (state_d)
      ENTER: begin
        target_d = src_nmi_d ? NMI_VECTOR : INT_VECTOR;
        cause_d  = src_nmi_d ? CAUSE_NMI : CAUSE_INT;
      end
      EXIT: begin
        target_d = src_nmi_d ? nmi_epc_d : epc_d;
        cause_d  = src_nmi_d ? CAUSE_NMI : CAUSE_INT;
      end
      IN_INT:  cause_d = CAUSE_INT;
      IN_NMI:  cause_d = CAUSE_NMI;
      default: cause_d = CAUSE_NONE;
    endcase
  end

endmodule

// File: tb/tb_mips_irq_controller.sv
// Directed bench for mips_irq_controller: per-cycle vector table plus hand-written corner sequences.
module tb_mips_irq_controller;

  logic        clk = 1'b0;
  logic        initiate;
  logic        int_line, intd_line, nmi_line;
  logic        instr_done, eret;
  logic [31:0] pc_next;
  logic        redirect, in_handler, int_ack, nmi_ack;
  logic [31:0] pc_target, epc, nmi_epc;
  logic [1:0]  cause;

  int tests = 0;
  int fails = 0;

  mips_irq_controller dut (
    .clk(clk), .initiate(initiate), .INT(int_line), .INTD(intd_line), .NMI(nmi_line),
    .instr_done(instr_done), .pc_next(pc_next), .eret(eret),
    .redirect(redirect), .pc_target(pc_target), .epc(epc), .nmi_epc(nmi_epc),
    .cause(cause), .in_handler(in_handler), .int_ack(int_ack), .nmi_ack(nmi_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nmi, intr, intd, done, er;
    logic [31:0] pc;
    logic        iack, nack, redir;
    logic [31:0] tgt;
    logic [1:0]  cs;
    logic        inh;
    logic [31:0] e, ne;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic nmi, intr, intd, done, er, input logic [31:0] pc,
                              input logic iack, nack, redir, input logic [31:0] tgt,
                              input logic [1:0] cs, input logic inh, input logic [31:0] e, ne);
    vec_t v;
    v.nmi = nmi; v.intr = intr; v.intd = intd; v.done = done; v.er = er; v.pc = pc;
    v.iack = iack; v.nack = nack; v.redir = redir; v.tgt = tgt; v.cs = cs; v.inh = inh;
    v.e = e; v.ne = ne;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Advance one cycle, drive boundary inputs, leave time for outputs to settle
  task automatic cyc(input logic d, input logic e, input logic [31:0] pc);
    @(posedge clk);
    #1;
    instr_done = d; eret = e; pc_next = pc;
    #3;
  endtask

  initial begin
    int found;
    initiate = 1'b0; int_line = 0; intd_line = 0; nmi_line = 0;
    instr_done = 0; eret = 0; pc_next = '0;

    // Basic INT entry and return, ERET in IDLE ignored
    tbl.push_back(mk(0,1,0,0,0,32'h00, 0,0,0,32'h00,0,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,0,32'h00, 0,0,0,32'h00,0,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,1,0,32'h40, 1,0,0,32'h00,0,0,32'h00,32'h00));
    tbl.push_back(mk(0,1,0,0,0,32'h00, 0,0,1,32'h80,1,1,32'h40,32'h00));
    tbl.push_back(mk(0,1,0,0,0,32'h00, 0,0,0,32'h00,1,1,32'h40,32'h00));
    tbl.push_back(mk(0,1,0,1,0,32'h44, 0,0,0,32'h00,1,1,32'h40,32'h00));
    tbl.push_back(mk(0,0,0,1,1,32'h48, 0,0,0,32'h00,1,1,32'h40,32'h00));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,1,32'h40,1,1,32'h40,32'h00));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,0,32'h00,0,0,32'h40,32'h00));
    tbl.push_back(mk(0,0,0,1,1,32'h4c, 0,0,0,32'h00,0,0,32'h40,32'h00));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,0,32'h00,0,0,32'h40,32'h00));
    // NMI preempts the INT handler, then nested unwind
    tbl.push_back(mk(0,1,0,0,0,32'h00, 0,0,0,32'h00,0,0,32'h40,32'h00));
    tbl.push_back(mk(0,1,0,0,0,32'h00, 0,0,0,32'h00,0,0,32'h40,32'h00));
    tbl.push_back(mk(0,1,0,1,0,32'h40, 1,0,0,32'h00,0,0,32'h40,32'h00));
    tbl.push_back(mk(1,0,0,0,0,32'h00, 0,0,1,32'h80,1,1,32'h40,32'h00));
    tbl.push_back(mk(1,0,0,0,0,32'h00, 0,0,0,32'h00,1,1,32'h40,32'h00));
    tbl.push_back(mk(1,0,0,0,0,32'h00, 0,0,0,32'h00,1,1,32'h40,32'h00));
    tbl.push_back(mk(1,0,0,1,0,32'h88, 0,1,0,32'h00,1,1,32'h40,32'h00));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,1,32'h100,2,1,32'h40,32'h88));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,0,32'h00,2,1,32'h40,32'h88));
    tbl.push_back(mk(0,0,0,1,1,32'h104,0,0,0,32'h00,2,1,32'h40,32'h88));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,1,32'h88,2,1,32'h40,32'h88));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,0,32'h00,1,1,32'h40,32'h88));
    tbl.push_back(mk(0,0,0,1,1,32'h8c, 0,0,0,32'h00,1,1,32'h40,32'h88));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,1,32'h40,1,1,32'h40,32'h88));
    tbl.push_back(mk(0,0,0,0,0,32'h00, 0,0,0,32'h00,0,0,32'h40,32'h88));

    #2;
    chk("rst_redirect", redirect, 0);
    chk("rst_target", pc_target, 0);
    chk("rst_cause", cause, 0);
    chk("rst_in_handler", in_handler, 0);
    chk("rst_epc", epc, 0);
    chk("rst_nmi_epc", nmi_epc, 0);
    #10 initiate = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      nmi_line = tbl[i].nmi; int_line = tbl[i].intr; intd_line = tbl[i].intd;
      instr_done = tbl[i].done; eret = tbl[i].er; pc_next = tbl[i].pc;
      #3;
      chk($sformatf("r%0d_int_ack", i), int_ack, tbl[i].iack);
      chk($sformatf("r%0d_nmi_ack", i), nmi_ack, tbl[i].nack);
      chk($sformatf("r%0d_redirect", i), redirect, tbl[i].redir);
      chk($sformatf("r%0d_target", i), pc_target, tbl[i].tgt);
      chk($sformatf("r%0d_cause", i), cause, tbl[i].cs);
      chk($sformatf("r%0d_in_handler", i), in_handler, tbl[i].inh);
      chk($sformatf("r%0d_epc", i), epc, tbl[i].e);
      chk($sformatf("r%0d_nmi_epc", i), nmi_epc, tbl[i].ne);
    end

    // INTD masks INT over many boundaries; clearing it admits INT after the sync delay
    int_line = 1; intd_line = 1;
    repeat (3) cyc(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 32'h10 + 32'(i));
      chk("mask_int_ack", int_ack, 0);
      chk("mask_redirect", redirect, 0);
    end
    intd_line = 0;
    found = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 32'h70);
      if (int_ack) begin
        found = i;
        break;
      end
    end
    chk("unmask_latency", 32'(found), 32'd1);
    cyc(0, 0, 0);
    chk("unmask_redirect", redirect, 1);
    chk("unmask_target", pc_target, 32'h80);
    chk("unmask_epc", epc, 32'h70);
    int_line = 0;
    cyc(0, 0, 0);
    cyc(1, 1, 32'h74);
    cyc(0, 0, 0);
    chk("unmask_ret_target", pc_target, 32'h70);
    cyc(0, 0, 0);
    chk("unmask_idle", in_handler, 0);
    repeat (3) cyc(0, 0, 0);

    // INT and NMI at the same boundary: NMI first, INT afterwards
    int_line = 1; nmi_line = 1;
    repeat (4) cyc(0, 0, 0);
    cyc(1, 0, 32'h20);
    chk("both_nmi_ack", nmi_ack, 1);
    chk("both_int_ack", int_ack, 0);
    cyc(0, 0, 0);
    chk("both_target", pc_target, 32'h100);
    chk("both_cause", cause, 2);
    chk("both_nmi_epc", nmi_epc, 32'h20);
    cyc(0, 0, 0);
    cyc(1, 1, 32'h200);
    cyc(0, 0, 0);
    chk("both_ret_target", pc_target, 32'h20);
    cyc(1, 0, 32'h24);
    chk("both_then_int_ack", int_ack, 1);
    cyc(0, 0, 0);
    chk("both_then_int_target", pc_target, 32'h80);
    chk("both_then_int_epc", epc, 32'h24);
    int_line = 0; nmi_line = 0;
    cyc(0, 0, 0);
    cyc(1, 1, 32'h28);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    repeat (3) cyc(0, 0, 0);

    // ERET and pending NMI at the same IN_INT boundary
    int_line = 1;
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 32'h30);
    chk("eret_nmi_int_ack", int_ack, 1);
    cyc(0, 0, 0);
    int_line = 0; nmi_line = 1;
    repeat (4) cyc(0, 0, 0);
    cyc(1, 1, 32'h34);
    chk("eret_nmi_no_ack", nmi_ack, 0);
    cyc(0, 0, 0);
    chk("eret_nmi_redirect", redirect, 1);
    chk("eret_nmi_target", pc_target, 32'h30);
    cyc(0, 0, 0);
    chk("eret_nmi_idle_redirect", redirect, 0);
    chk("eret_nmi_idle_cause", cause, 0);
    chk("eret_nmi_idle_inh", in_handler, 0);
    cyc(1, 0, 32'h50);
    chk("eret_nmi_late_ack", nmi_ack, 1);
    cyc(0, 0, 0);
    chk("eret_nmi_late_target", pc_target, 32'h100);
    chk("eret_nmi_late_epc", nmi_epc, 32'h50);
    cyc(0, 0, 0);
    chk("in_nmi_cause", cause, 2);

    // Asynchronous reset in the middle of an NMI handler
    #1;
    nmi_line = 0;
    initiate = 0;
    #1;
    chk("mid_rst_redirect", redirect, 0);
    chk("mid_rst_target", pc_target, 0);
    chk("mid_rst_cause", cause, 0);
    chk("mid_rst_inh", in_handler, 0);
    chk("mid_rst_epc", epc, 0);
    chk("mid_rst_nmi_epc", nmi_epc, 0);
    chk("mid_rst_acks", {int_ack, nmi_ack}, 0);
    #2 initiate = 1;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 32'h60);
      chk("post_rst_redirect", redirect, 0);
      chk("post_rst_acks", {int_ack, nmi_ack}, 0);
      chk("post_rst_inh", in_handler, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
